bserializer: RTL and testbench

BSERIALIZER -- requirements
Module: bserializer

---
 rtl/bserializer.sv | 125 ++++++++++++
 tb/tb_bserializer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/bserializer.sv
// Parallel-to-serial converter with a one-word hold register so back-to-back words stream without gaps.
// Define BSERIALIZER_LSB_FIRST_EN for LSB-first output; the default is MSB first.
module bserializer #(
  parameter int BITS = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_sclr,
  input  logic            i_en,
  input  logic            i_load_valid,
  input  logic [BITS-1:0] i_data,
  output logic            o_load_ready,
  output logic            o_dat,
  output logic            o_dvalid,
  output logic            o_last,
  output logic            o_busy
);

  localparam int CW = (BITS > 2) ? $clog2(BITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(BITS - 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BITS-1:0] shreg_q, shreg_d;
  logic [BITS-1:0] hold_q, hold_d;
  logic            hold_full_q, hold_full_d;
  logic [BITS-1:0] shreg_shift;
  logic            out_bit;
  logic            accept;
  logic            final_tick;

  assign accept     = i_load_valid & ~hold_full_q;
  assign final_tick = (state_q == SHIFT) && i_en && (cnt_q == LAST);

`ifdef BSERIALIZER_LSB_FIRST_EN
  assign shreg_shift = {1'b0, shreg_q[BITS-1:1]};
  assign out_bit     = shreg_q[0];
`else
  assign shreg_shift = {shreg_q[BITS-2:0], 1'b0};
  assign out_bit     = shreg_q[BITS-1];
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shreg_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (i_sclr) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (accept) state_d = SHIFT;
        SHIFT:   if (final_tick && !hold_full_q && !accept) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Datapath next state; an accept on the final-bit edge with hold empty bypasses the hold register.
  always_comb begin
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    if (i_sclr) begin
      cnt_d       = '0;
      shreg_d     = '0;
      hold_d      = '0;
      hold_full_d = 1'b0;
    end else if (state_q == IDLE) begin
      if (accept) begin
        shreg_d = i_data;
        cnt_d   = '0;
      end
    end else if (final_tick) begin
      cnt_d = '0;
      if (hold_full_q) begin
        shreg_d     = hold_q;
        hold_d      = '0;
        hold_full_d = 1'b0;
      end else if (accept) begin
        shreg_d = i_data;
      end else begin
        shreg_d = '0;
      end
    end else begin
      if (i_en) begin
        shreg_d = shreg_shift;
        cnt_d   = cnt_q + CW'(1);
      end
      if (accept) begin
        hold_d      = i_data;
        hold_full_d = 1'b1;
      end
    end
  end

  always_comb begin
    o_dvalid     = (state_q == SHIFT);
    o_dat        = 1'b0;
    o_last       = 1'b0;
    if (state_q == SHIFT) begin
      o_dat  = out_bit;
      o_last = (cnt_q == LAST);
    end
    o_busy       = (state_q == SHIFT) | hold_full_q;
    o_load_ready = ~hold_full_q;
  end

endmodule

// File: tb/tb_bserializer.sv
// Scoreboard bench for bserializer (BITS=8): loads push expected bit streams, a negedge monitor pops and compares.
module tb_bserializer;
  localparam int BITS = 8;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            i_sclr = 1'b0;
  logic            i_en = 1'b1;
  logic            i_load_valid = 1'b0;
  logic [BITS-1:0] i_data = '0;
  logic            o_load_ready, o_dat, o_dvalid, o_last, o_busy;

  int checks = 0;
  int errors = 0;
  logic [1:0] exp_q[$];   // {last, bit}

  bserializer #(.BITS(BITS)) dut (
    .clk(clk), .reset(reset), .i_sclr(i_sclr), .i_en(i_en),
    .i_load_valid(i_load_valid), .i_data(i_data),
    .o_load_ready(o_load_ready), .o_dat(o_dat), .o_dvalid(o_dvalid),
    .o_last(o_last), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected serial order of a word, hand-derived: the word as written (MSB first) or bit-reversed.
  function automatic logic [7:0] stream_of(input logic [7:0] w);
`ifdef BSERIALIZER_LSB_FIRST_EN
    return {w[0], w[1], w[2], w[3], w[4], w[5], w[6], w[7]};
`else
    return w;
`endif
  endfunction

  task automatic push_word(input logic [7:0] w);
    logic [7:0] s;
    s = stream_of(w);
    for (int i = 0; i < 8; i++) exp_q.push_back({(i == 7) ? 1'b1 : 1'b0, s[7-i]});
  endtask

  // Monitor: a bit is consumed on an edge with o_dvalid && i_en; a stalled bit must match the queue head.
  always @(negedge clk) begin
    if (!reset && o_dvalid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_bit", 32'(o_dvalid), 32'd0);
      end else begin
        logic [1:0] e;
        e = exp_q[0];
        check("ser_bit", 32'(o_dat), 32'(e[0]));
        check("ser_last", 32'(o_last), 32'(e[1]));
        if (i_en) void'(exp_q.pop_front());
      end
    end
  end

  task automatic load_word(input logic [7:0] w);
    bit ok;
    ok = 0;
    i_data = w;
    i_load_valid = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (o_load_ready) begin ok = 1; break; end
    end
    if (!ok) check("load_timeout", 32'd0, 32'd1);
    @(posedge clk);
    push_word(w);
    #1 i_load_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (!o_busy && !o_dvalid) begin ok = 1; break; end
    end
    check({name, "_idle"}, 32'(ok), 32'd1);
    check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_dat"}, 32'(o_dat), 32'd0);
    check({name, "_dvalid"}, 32'(o_dvalid), 32'd0);
    check({name, "_last"}, 32'(o_last), 32'd0);
    check({name, "_busy"}, 32'(o_busy), 32'd0);
    check({name, "_ready"}, 32'(o_load_ready), 32'd1);
  endtask

  initial begin
    bit ok;
    #12;
    check_reset_outputs("reset");
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;

    // Single word, continuous enable: C1 then idle
    i_en = 1'b1;
    load_word(8'hC1);
    @(negedge clk);
    check("load_latency_dvalid", 32'(o_dvalid), 32'd1);
    wait_idle("single");
    $display("txn single C1 done, checks=%0d errors=%0d", checks, errors);

    // Back-to-back: C1 then 3C via the hold register, no gap
    @(posedge clk); #1;
    load_word(8'hC1);
    load_word(8'h3C);
    @(negedge clk);
    check("hold_ready_low", 32'(o_load_ready), 32'd0);
    check("hold_busy", 32'(o_busy), 32'd1);
    for (int n = 0; n < 40 && exp_q.size() > 1; n++) begin
      check("b2b_no_gap", 32'(o_dvalid), 32'd1);
      @(negedge clk);
    end
    check("ready_after_handoff", 32'(o_load_ready), 32'd1);
    wait_idle("b2b");
    $display("txn back-to-back C1,3C done, checks=%0d errors=%0d", checks, errors);

    // Direct load on the final-bit edge with hold empty
    @(posedge clk); #1;
    load_word(8'hA5);
    ok = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (o_last) begin ok = 1; break; end
    end
    check("final_edge_wait", 32'(ok), 32'd1);
    i_data = 8'h5A;
    i_load_valid = 1'b1;
    @(posedge clk);
    push_word(8'h5A);
    #1 i_load_valid = 1'b0;
    @(negedge clk);
    check("direct_load_dvalid", 32'(o_dvalid), 32'd1);
    check("direct_load_ready", 32'(o_load_ready), 32'd1);
    wait_idle("direct");
    $display("txn final-edge direct load A5,5A done, checks=%0d errors=%0d", checks, errors);

    // Enable toggling 1,0,1,0: each bit held two cycles
    @(posedge clk); #1;
    i_en = 1'b0;
    load_word(8'hC1);
    for (int k = 0; k < 16; k++) begin
      i_en = (k % 2 == 0);
      @(posedge clk); #1;
    end
    i_en = 1'b1;
    wait_idle("toggle");
    $display("txn enable-toggle C1 done, checks=%0d errors=%0d", checks, errors);

    // i_en in IDLE is ignored
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("idle_en_ignored", 32'(o_dvalid), 32'd0);

    // Sync clear after 3 bits with hold full
    @(posedge clk); #1;
    load_word(8'hC1);
    load_word(8'h3C);
    @(posedge clk); #1;
    check("sclr_pre_ready", 32'(o_load_ready), 32'd0);
    i_sclr = 1'b1;
    i_en = 1'b0;
    i_data = 8'hFF;
    i_load_valid = 1'b1;
    @(posedge clk); #1;
    i_sclr = 1'b0;
    i_load_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check_reset_outputs("sclr");
    i_en = 1'b1;
    $display("txn sclr mid-word done, checks=%0d errors=%0d", checks, errors);

    // Async reset mid-word
    @(posedge clk); #1;
    load_word(8'hC1);
    load_word(8'h3C);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    exp_q.delete();
    #4 reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("post_reset");
    $display("txn async reset mid-word done, checks=%0d errors=%0d", checks, errors);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
